nsnr_latch_drv: RTL and testbench
=================================

# nsnr_latch_drv

Synchronous driver for the active-low set/reset latch cell. Accepts single-cycle set/clear commands on the clock domain and turns each into a registered, width-controlled active-low pulse on exactly one of the latch's two inputs, never both. It reads the latch's q back through a 2-flop synchronizer, confirms the state change, and reports completion, or a timeout error, through a one-cycle acknowledge.

## Interface
- PW, default 2: pulse width in clock cycles; legal range 1..15.
- TO, default 8: settle timeout in clock cycles; legal range 2..255.
- ck  input  1  clock; all state changes on the rising edge.
- nrst  input  1  reset; asynchronous and active-low.
- req  input  1  command request; sampled only when busy=0.
- cmd  input  1  command: 1 = set (q→1), 0 = clear (q→0); sampled with req.
- busy  output  1  high from the accept edge until the ack edge.
- ack  output  1  one-cycle completion strobe.
- err  output  1  valid only with ack; 1 = timeout, latch did not reach the commanded state.
- l_nset  output  1  to latch nset; active-low, registered.
- l_nrst  output  1  to latch nrst; active-low, registered.
- l_q  input  1  latch q readback; asynchronous, synchronized internally.
- q_sync  output  1  synchronized latch state (second synchronizer flop).

## Operation
- Reset (nrst=0) forces, asynchronously:
  - l_nset=1, l_nrst=1;
  - busy=0, ack=0, err=0;
  - q_sync=0, with both synchronizer flops at 0;
  - state IDLE, all counters 0.
- States: IDLE, PULSE, SETTLE.
- IDLE:
  - req=1 at an edge: latch cmd into cmd_r, enter PULSE, set busy=1.
  - On the same edge, drive l_nset=0 if cmd=1, else l_nrst=0.
- PULSE:
  - The selected output stays low for exactly PW cycles; pulse counter counts 0..PW-1.
  - On the edge after count PW-1, both outputs go high, settle counter clears, state enters SETTLE.
- SETTLE, evaluated each cycle:
  - If q_sync==cmd_r: next edge gives ack=1, err=0, busy=0, state IDLE.
  - Else if settle counter==TO-1: next edge gives ack=1, err=1, busy=0, state IDLE.
  - Else: increment the settle counter.
- ack and err are registered and high for exactly one cycle. err is 0 whenever ack=0.
- Commands are always pulsed, even when q_sync already equals cmd. This confirms immediately in SETTLE.
- req while busy=1 is ignored, not queued. The requester must hold req or re-issue it after ack.
- A new req can be accepted on the edge where ack deasserts, i.e. the cycle after ack.
- Invariant: l_nset and l_nrst are never both 0, in any cycle and across reset.
- Reset mid-PULSE: the low output returns high asynchronously. No ack is issued and the command is dropped.

## Timing
- Accept at edge n. l_nset/l_nrst are low for edges n..n+PW-1 and high from edge n+PW.
- Synchronizer latency: 2 edges from an l_q change to a q_sync change.
- With an ideal latch (q follows the pulse within the same cycle), ack rises at edge n+max(PW,2)+1.
  - PW=2: ack at n+3.
  - PW=1: ack at n+3.
  - PW=4: ack at n+5.
- Timeout: ack with err=1 rises at edge n+PW+TO.
- busy is high for edges n..(ack edge)-1 and low at the ack edge.
- Counter widths: 4 bits for the pulse counter, 8 bits for the settle counter; no wrap inside legal ranges.

## Structure
- Shared package nsnr_latch_pkg:
  - state enum (IDLE, PULSE, SETTLE);
  - constants CMD_SET=1, CMD_CLR=0;
  - PW/TO range limits and counter width constants.
- One sub-module: sync2, a 2-flop synchronizer with async active-low reset to 0, used for l_q.
- Top level holds the FSM, the two counters and the registered latch drives. Roughly 150–250 lines.

## Test plan
- Reset:
  - Assert nrst=0 mid-PULSE with l_nset=0. l_nset=1 immediately, with no ack after release.
  - busy=0, q_sync=0, and both l_* outputs are 1 throughout reset.
- Set with a behavioural latch model, PW=2:
  - req=1, cmd=1 at edge 10. l_nset is low at edges 10–11 and high at 12.
  - q_sync=1 by edge 12. ack=1, err=0 at edge 13; busy is high at edges 10–12.
- Clear, then set again, PW=4:
  - Sequence clear → set. Each ack arrives 5 cycles after accept, with err=0.
  - The l_nrst pulse is 4 cycles wide; l_nset/l_nrst are never simultaneously 0.
- Timeout, TO=8, PW=2:
  - Stuck latch model (l_q tied 0), cmd=1 accepted at edge 20.
  - ack=1, err=1 at edge 30; back to IDLE.
- req held high across ack:
  - Second command accepted the cycle after ack.
  - req pulses during busy produce no extra pulses or acks.
- Redundant command:
  - q already 1, cmd=1. Pulse still issued; ack, err=0 at n+3.

Source files
------------

// File: rtl/nsnr_latch_pkg.sv
// Shared definitions for the active-low set/reset latch driver: FSM states,
// command encodings, parameter limits and counter widths.
package nsnr_latch_pkg;

    // Driver sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2
    } state_e;

    // Command encodings carried on cmd
    localparam logic CMD_SET = 1'b1;
    localparam logic CMD_CLR = 1'b0;

    // Legal parameter ranges
    localparam int PW_MIN = 1;
    localparam int PW_MAX = 15;
    localparam int TO_MIN = 2;
    localparam int TO_MAX = 255;

    // Counter widths, sized so that the legal ranges never wrap
    localparam int PCNT_W = 4;
    localparam int SCNT_W = 8;

    // Clamp a parameter into its legal range so an out-of-range setting
    // can never overflow a counter or produce a zero-length pulse.
    function automatic int clampInt(input int value, input int lo, input int hi);
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/nsnr_latch_drv_sync2.sv
// Two-flop synchronizer for the asynchronous latch readback.
// Both flops clear to 0 on reset so the reported state starts low.
module sync2 (
    input  logic ck,
    input  logic nrst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops to resolve metastability
    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/nsnr_latch_drv.sv
// Synchronous driver for an active-low set/reset latch cell.
// Each accepted command produces one registered, PW-cycle-wide low pulse on
// exactly one latch input, then waits for the synchronized readback to reach
// the commanded level (or for TO cycles to pass) and reports via ack/err.
module nsnr_latch_drv
    import nsnr_latch_pkg::*;
#(
    parameter int PW = 2,
    parameter int TO = 8
) (
    input  logic ck,
    input  logic nrst,
    input  logic req,
    input  logic cmd,
    output logic busy,
    output logic ack,
    output logic err,
    output logic l_nset,
    output logic l_nrst,
    input  logic l_q,
    output logic q_sync
);

    // Effective widths after clamping into the legal range
    localparam int PW_EFF = clampInt(PW, PW_MIN, PW_MAX);
    localparam int TO_EFF = clampInt(TO, TO_MIN, TO_MAX);

    // Terminal counts for the pulse and settle counters
    localparam logic [PCNT_W-1:0] PW_LAST = PCNT_W'(PW_EFF - 1);
    localparam logic [SCNT_W-1:0] TO_LAST = SCNT_W'(TO_EFF - 1);

    state_e              state_q, state_d;
    logic                cmd_q, cmd_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                nsetDrv_q, nsetDrv_d;
    logic                nrstDrv_q, nrstDrv_d;
    logic                qSync;

    sync2 u_sync2 (
        .ck   (ck),
        .nrst (nrst),
        .d_i  (l_q),
        .q_o  (qSync)
    );

    // Next-state logic: accept a command, time the pulse, then confirm or time out
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        pcnt_d    = pcnt_q;
        scnt_d    = scnt_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        nsetDrv_d = nsetDrv_q;
        nrstDrv_d = nrstDrv_q;

        case (state_q)
            IDLE: begin
                // Both drives idle high; a request starts the pulse on the same edge
                nsetDrv_d = 1'b1;
                nrstDrv_d = 1'b1;
                if (req) begin
                    cmd_d     = cmd;
                    state_d   = PULSE;
                    busy_d    = 1'b1;
                    pcnt_d    = '0;
                    nsetDrv_d = (cmd != CMD_SET);
                    nrstDrv_d = (cmd != CMD_CLR);
                end
            end

            PULSE: begin
                if (pcnt_q == PW_LAST) begin
                    nsetDrv_d = 1'b1;
                    nrstDrv_d = 1'b1;
                    scnt_d    = '0;
                    state_d   = SETTLE;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end

            SETTLE: begin
                // Commands are always pulsed, so an already-matching latch
                // simply confirms on the first settle cycle.
                if (qSync == cmd_q) begin
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (scnt_q == TO_LAST) begin
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                nsetDrv_d = 1'b1;
                nrstDrv_d = 1'b1;
            end
        endcase

        // Never let both latch inputs go low together, whatever the state
        if (!nsetDrv_d && !nrstDrv_d) begin
            nrstDrv_d = 1'b1;
        end
    end

    // State and output registers; reset releases both latch inputs high at once
    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            cmd_q     <= CMD_CLR;
            pcnt_q    <= '0;
            scnt_q    <= '0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            nsetDrv_q <= 1'b1;
            nrstDrv_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            pcnt_q    <= pcnt_d;
            scnt_q    <= scnt_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            nsetDrv_q <= nsetDrv_d;
            nrstDrv_q <= nrstDrv_d;
        end
    end

    assign busy   = busy_q;
    assign ack    = ack_q;
    assign err    = err_q;
    assign l_nset = nsetDrv_q;
    assign l_nrst = nrstDrv_q;
    assign q_sync = qSync;

endmodule

// File: tb/tb_nsnr_latch_drv.sv
// Self-checking bench for nsnr_latch_drv: two instances (PW=2 and PW=4,
// both TO=8), each driving its own behavioural latch model.
module tb_nsnr_latch_drv;

    typedef struct {
        int   dutSel;
        logic cmdVal;
        logic stuck;
        int   expAck;
        logic expErr;
        int   expLow;
    } vec_t;

    logic ck = 1'b0;
    logic nrst = 1'b0;
    logic cmd = 1'b0;
    logic req2 = 1'b0;
    logic req4 = 1'b0;

    logic busy2, ack2, err2, nset2, nrstL2, qSync2;
    logic busy4, ack4, err4, nset4, nrstL4, qSync4;
    logic latchQ2 = 1'b0;
    logic latchQ4 = 1'b0;
    logic stuck2 = 1'b0;
    logic stuck4 = 1'b0;

    int checks = 0;
    int errors = 0;

    nsnr_latch_drv #(.PW(2), .TO(8)) u_dut2 (
        .ck     (ck),
        .nrst   (nrst),
        .req    (req2),
        .cmd    (cmd),
        .busy   (busy2),
        .ack    (ack2),
        .err    (err2),
        .l_nset (nset2),
        .l_nrst (nrstL2),
        .l_q    (latchQ2),
        .q_sync (qSync2)
    );

    nsnr_latch_drv #(.PW(4), .TO(8)) u_dut4 (
        .ck     (ck),
        .nrst   (nrst),
        .req    (req4),
        .cmd    (cmd),
        .busy   (busy4),
        .ack    (ack4),
        .err    (err4),
        .l_nset (nset4),
        .l_nrst (nrstL4),
        .l_q    (latchQ4),
        .q_sync (qSync4)
    );

    always #5 ck = ~ck;

    // Behavioural SR latches; a stuck latch holds q at 0
    always @(nset2 or nrstL2 or stuck2) begin
        if (stuck2) latchQ2 = 1'b0;
        else if (!nset2) latchQ2 = 1'b1;
        else if (!nrstL2) latchQ2 = 1'b0;
    end

    always @(nset4 or nrstL4 or stuck4) begin
        if (stuck4) latchQ4 = 1'b0;
        else if (!nset4) latchQ4 = 1'b1;
        else if (!nrstL4) latchQ4 = 1'b0;
    end

    // Global watchdog so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic sampleDut(input int sel, output logic b, output logic a, output logic e,
                             output logic ns, output logic nr, output logic qs);
        if (sel == 2) begin
            b = busy2; a = ack2; e = err2; ns = nset2; nr = nrstL2; qs = qSync2;
        end else begin
            b = busy4; a = ack4; e = err4; ns = nset4; nr = nrstL4; qs = qSync4;
        end
    endtask

    // Raise req for one edge on the selected DUT; returns #1 after the accept edge
    task automatic applyStimulus(input int sel, input logic cmdVal);
        @(negedge ck);
        cmd = cmdVal;
        if (sel == 2) req2 = 1'b1; else req4 = 1'b1;
        @(posedge ck);
        #1;
        req2 = 1'b0;
        req4 = 1'b0;
    endtask

    task automatic runVector(input int idx, input vec_t v);
        logic b, a, e, ns, nr, qs;
        int ackOff, errAt, busyAtAck, lowCnt, bothLow, ackCnt, busyCnt, errNoAck;
        if (v.dutSel == 2) stuck2 = v.stuck; else stuck4 = v.stuck;
        repeat (4) @(posedge ck);
        applyStimulus(v.dutSel, v.cmdVal);
        sampleDut(v.dutSel, b, a, e, ns, nr, qs);
        ackOff = -1; errAt = 0; busyAtAck = 1; ackCnt = 0; errNoAck = 0;
        busyCnt = b ? 1 : 0;
        bothLow = (!ns && !nr) ? 1 : 0;
        lowCnt = (v.cmdVal ? !ns : !nr) ? 1 : 0;
        checkOutput($sformatf("vec%0d busy_at_accept", idx), int'(b), 1);
        for (int k = 1; k <= 40; k++) begin
            @(posedge ck);
            #1;
            sampleDut(v.dutSel, b, a, e, ns, nr, qs);
            if (!ns && !nr) bothLow++;
            if (v.cmdVal ? !ns : !nr) lowCnt++;
            if (!a && e) errNoAck++;
            if (b) busyCnt++;
            if (a) begin
                ackCnt++;
                if (ackOff < 0) begin
                    ackOff = k;
                    errAt = int'(e);
                    busyAtAck = int'(b);
                end
            end
        end
        checkOutput($sformatf("vec%0d ack_offset", idx), ackOff, v.expAck);
        checkOutput($sformatf("vec%0d err", idx), errAt, int'(v.expErr));
        checkOutput($sformatf("vec%0d pulse_width", idx), lowCnt, v.expLow);
        checkOutput($sformatf("vec%0d both_low", idx), bothLow, 0);
        checkOutput($sformatf("vec%0d ack_count", idx), ackCnt, 1);
        checkOutput($sformatf("vec%0d busy_at_ack", idx), busyAtAck, 0);
        checkOutput($sformatf("vec%0d busy_cycles", idx), busyCnt, v.expAck);
        checkOutput($sformatf("vec%0d err_without_ack", idx), errNoAck, 0);
        stuck2 = 1'b0;
        stuck4 = 1'b0;
    endtask

    // Main sequence: reset checks, table vectors, then multi-cycle corner cases
    initial begin
        vec_t vecs[$];
        int ackCnt, firstAck, secondAck, lowCnt;

        vecs.push_back('{2, 1'b1, 1'b0, 3,  1'b0, 2});
        vecs.push_back('{2, 1'b1, 1'b0, 3,  1'b0, 2});
        vecs.push_back('{2, 1'b0, 1'b0, 3,  1'b0, 2});
        vecs.push_back('{2, 1'b0, 1'b0, 3,  1'b0, 2});
        vecs.push_back('{2, 1'b1, 1'b1, 10, 1'b1, 2});
        vecs.push_back('{2, 1'b0, 1'b1, 3,  1'b0, 2});
        vecs.push_back('{4, 1'b0, 1'b0, 5,  1'b0, 4});
        vecs.push_back('{4, 1'b1, 1'b0, 5,  1'b0, 4});
        vecs.push_back('{4, 1'b1, 1'b1, 12, 1'b1, 4});
        vecs.push_back('{4, 1'b0, 1'b0, 5,  1'b0, 4});

        // Outputs held in their reset values while nrst is low
        repeat (3) @(posedge ck);
        #1;
        checkOutput("reset busy", int'(busy2), 0);
        checkOutput("reset ack", int'(ack2), 0);
        checkOutput("reset err", int'(err2), 0);
        checkOutput("reset q_sync", int'(qSync2), 0);
        checkOutput("reset l_nset", int'(nset2), 1);
        checkOutput("reset l_nrst", int'(nrstL2), 1);
        checkOutput("reset l_nset pw4", int'(nset4), 1);
        @(negedge ck);
        nrst = 1'b1;
        repeat (2) @(posedge ck);

        // Reset in the middle of a set pulse on the PW=4 instance
        applyStimulus(4, 1'b1);
        checkOutput("midpulse l_nset low", int'(nset4), 0);
        @(negedge ck);
        nrst = 1'b0;
        #1;
        checkOutput("midpulse l_nset async high", int'(nset4), 1);
        checkOutput("midpulse busy cleared", int'(busy4), 0);
        checkOutput("midpulse q_sync cleared", int'(qSync4), 0);
        @(negedge ck);
        nrst = 1'b1;
        ackCnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge ck);
            #1;
            if (ack4) ackCnt++;
        end
        checkOutput("midpulse no ack", ackCnt, 0);
        checkOutput("midpulse idle busy", int'(busy4), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            runVector(i, vecs[i]);
        end

        // req held high across ack: second command accepted the cycle after ack
        repeat (4) @(posedge ck);
        @(negedge ck);
        cmd = 1'b1;
        req2 = 1'b1;
        @(posedge ck);
        #1;
        ackCnt = 0; firstAck = -1; secondAck = -1;
        lowCnt = nset2 ? 0 : 1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge ck);
            #1;
            if (!nset2) lowCnt++;
            if (ack2) begin
                ackCnt++;
                if (firstAck < 0) firstAck = k;
                else secondAck = k;
            end
            if (k == 4) begin
                checkOutput("held reaccept busy", int'(busy2), 1);
                checkOutput("held reaccept l_nset", int'(nset2), 0);
                req2 = 1'b0;
            end
        end
        checkOutput("held ack count", ackCnt, 2);
        checkOutput("held first ack", firstAck, 3);
        checkOutput("held second ack", secondAck, 7);
        checkOutput("held pulse cycles", lowCnt, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
